// File: rtl/float_mult_pipe.sv
// float_mult_pipe: 3-stage IEEE-754-style multiplier (RNE, flush-to-zero); define FMUL_FLAGS_EN to build exception flags
module float_mult_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 EN,
   input  logic                 in_valid,
   input  logic [EXP_W+MAN_W:0] A,
   input  logic [EXP_W+MAN_W:0] B,
   output logic                 out_valid,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 invalid
);
   localparam int PW = 2*MAN_W+2;
   localparam logic [EXP_W+1:0] BIAS_X = {3'b000, {(EXP_W-1){1'b1}}};
   localparam logic [EXP_W+1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
   typedef enum logic [1:0] {C_NORM, C_ZERO, C_INF, C_NAN} cls_t;
   logic [EXP_W-1:0] ea, eb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inv_d;
   cls_t             cls_d, cls1_q, cls2_q;
   logic [PW-1:0]    p_d, p1_q;
   logic [EXP_W+1:0] e_d, e1_q, e2_q, e3_d;
   logic             v1_q, v2_q, sgn1_q, sgn2_q, msb_d;
   logic [PW-2:0]    pn_d;
   logic [MAN_W-1:0] f2_q;
   logic             g2_q, r2_q, st2_q, inc_d, ovf_d, unf_d;
   logic [MAN_W:0]   sum_d;
   logic [EXP_W+MAN_W:0] res_d;
   assign ea     = A[MAN_W+:EXP_W];
   assign eb     = B[MAN_W+:EXP_W];
   assign a_zero = ea == '0;
   assign b_zero = eb == '0;
   assign a_inf  = (&ea) & ~|A[MAN_W-1:0];
   assign b_inf  = (&eb) & ~|B[MAN_W-1:0];
   assign a_nan  = (&ea) & |A[MAN_W-1:0];
   assign b_nan  = (&eb) & |B[MAN_W-1:0];
   assign inv_d  = (a_inf & b_zero) | (a_zero & b_inf);
   assign cls_d  = (a_nan | b_nan | inv_d) ? C_NAN : (a_inf | b_inf) ? C_INF : (a_zero | b_zero) ? C_ZERO : C_NORM;
   assign p_d    = {{(MAN_W+1){1'b0}}, 1'b1, A[MAN_W-1:0]} * {{(MAN_W+1){1'b0}}, 1'b1, B[MAN_W-1:0]};
   assign e_d    = {2'b00, ea} + {2'b00, eb} - BIAS_X;
   assign msb_d  = p1_q[PW-1];
   assign pn_d   = msb_d ? p1_q[PW-2:0] : {p1_q[PW-3:0], 1'b0};
   assign inc_d  = g2_q & (r2_q | st2_q | f2_q[0]);
   assign sum_d  = {1'b0, f2_q} + {{MAN_W{1'b0}}, inc_d};
   assign e3_d   = e2_q + {{(EXP_W+1){1'b0}}, sum_d[MAN_W]};
   assign ovf_d  = (cls2_q == C_NORM) & ~e3_d[EXP_W+1] & (e3_d >= EMAX);
   assign unf_d  = (cls2_q == C_NORM) & (e3_d[EXP_W+1] | (e3_d == '0));
   assign res_d  = (cls2_q == C_NAN) ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
                   (cls2_q == C_INF || ovf_d) ? {sgn2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                   (cls2_q == C_ZERO || unf_d) ? {sgn2_q, {(EXP_W+MAN_W){1'b0}}} :
                   {sgn2_q, e3_d[EXP_W-1:0], sum_d[MAN_W-1:0]};
   // S1: classify operands, form the raw mantissa product and biased exponent sum
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1_q   <= 1'b0;
         cls1_q <= C_NORM;
         sgn1_q <= 1'b0;
         p1_q   <= '0;
         e1_q   <= '0;
      end else if (EN) begin
         v1_q   <= in_valid;
         cls1_q <= cls_d;
         sgn1_q <= A[EXP_W+MAN_W] ^ B[EXP_W+MAN_W];
         p1_q   <= p_d;
         e1_q   <= e_d;
      end
   // S2: normalise by at most one place and split fraction into kept bits, guard, round and sticky
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v2_q   <= 1'b0;
         cls2_q <= C_NORM;
         sgn2_q <= 1'b0;
         f2_q   <= '0;
         g2_q   <= 1'b0;
         r2_q   <= 1'b0;
         st2_q  <= 1'b0;
         e2_q   <= '0;
      end else if (EN) begin
         v2_q   <= v1_q;
         cls2_q <= cls1_q;
         sgn2_q <= sgn1_q;
         f2_q   <= pn_d[PW-2:MAN_W+1];
         g2_q   <= pn_d[MAN_W];
         r2_q   <= pn_d[MAN_W-1];
         st2_q  <= |pn_d[MAN_W-2:0];
         e2_q   <= e1_q + {{(EXP_W+1){1'b0}}, msb_d};
      end
   // S3: round to nearest even, range-check, register result; result holds across bubbles
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
      end else if (EN) begin
         out_valid <= v2_q;
         if (v2_q) result <= res_d;
      end
`ifdef FMUL_FLAGS_EN
   logic inv1_q, inv2_q, ovf_q, unf_q, inv_q;
   // Exception flags travel alongside the data and are only raised with a valid result
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         inv1_q <= 1'b0;
         inv2_q <= 1'b0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         inv_q  <= 1'b0;
      end else if (EN) begin
         inv1_q <= inv_d;
         inv2_q <= inv1_q;
         ovf_q  <= v2_q & ovf_d;
         unf_q  <= v2_q & unf_d;
         inv_q  <= v2_q & inv2_q;
      end
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign invalid   = inv_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
   assign invalid   = 1'b0;
`endif
endmodule

// File: tb/tb_float_mult_pipe.sv
// tb_float_mult_pipe: random and directed checks of float_mult_pipe against a real-arithmetic reference
module tb_float_mult_pipe;
   logic        clk = 1'b0;
   logic        rst_n, en, in_valid, out_valid, ovf, unf, inv;
   logic [31:0] a, b, result;
   typedef struct {bit v; logic [31:0] r; logic [2:0] f;} op_t;
   op_t         pipe [3];
   logic [31:0] last_r;
   int          n_tests = 0, n_fail = 0;
`ifdef FMUL_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif
   float_mult_pipe dut (
      .clk(clk), .rst_n(rst_n), .EN(en), .in_valid(in_valid), .A(a), .B(b),
      .out_valid(out_valid), .result(result), .overflow(ovf), .underflow(unf), .invalid(inv)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic real pow2(input int k);
      real r = 1.0;
      for (int i = 0; i < (k < 0 ? -k : k); i++) r = (k < 0) ? r * 0.5 : r * 2.0;
      return r;
   endfunction
   // Reference: exact product in double precision, then RNE to single with flush-to-zero
   function automatic op_t ref_mul(input logic [31:0] x, input logic [31:0] y);
      op_t         o;
      logic [7:0]  ex = x[30:23], ey = y[30:23];
      logic [22:0] fx = x[22:0], fy = y[22:0];
      bit          zx = (ex == 0), zy = (ey == 0);
      bit          ix = (ex == 8'hFF) && (fx == 0), iy = (ey == 8'hFF) && (fy == 0);
      bit          nx = (ex == 8'hFF) && (fx != 0), ny = (ey == 8'hFF) && (fy != 0);
      bit          s = x[31] ^ y[31];
      real         p;
      logic [63:0] bits;
      int          de;
      logic [22:0] keep;
      logic [28:0] rem;
      logic [23:0] m;
      o.v = 1'b1;
      o.f = 3'b000;
      if (nx || ny || (ix && zy) || (zx && iy)) begin
         o.r = 32'h7FC00000;
         o.f[0] = (ix && zy) || (zx && iy);
      end else if (ix || iy) o.r = {s, 8'hFF, 23'h0};
      else if (zx || zy) o.r = {s, 31'h0};
      else begin
         p = (1.0 + real'(fx) / 8388608.0) * pow2(int'(ex) - 127) *
             (1.0 + real'(fy) / 8388608.0) * pow2(int'(ey) - 127);
         bits = $realtobits(p);
         de = int'(bits[62:52]) - 1023 + 127;
         keep = bits[51:29];
         rem = bits[28:0];
         m = {1'b0, keep} + 24'((rem > 29'h10000000) || (rem == 29'h10000000 && keep[0]));
         if (m[23]) de++;
         if (de >= 255) begin
            o.r = {s, 8'hFF, 23'h0};
            o.f[2] = 1'b1;
         end else if (de <= 0) begin
            o.r = {s, 31'h0};
            o.f[1] = 1'b1;
         end else o.r = {s, 8'(de), m[22:0]};
      end
      return o;
   endfunction
   function automatic logic [31:0] rand_fp();
      int          k = $urandom_range(0, 15);
      logic [7:0]  e;
      logic [22:0] f = 23'($urandom);
      e = (k == 0) ? 8'h00 : (k <= 2) ? 8'hFF : (k < 8) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154));
      if (k == 1) f = '0;
      return {1'($urandom), e, f};
   endfunction
   // Cycle-level model: three enabled-edge delay line of expected results, checked every cycle
   always @(posedge clk) begin
      if (!rst_n) begin
         foreach (pipe[i]) pipe[i] = '{1'b0, 32'h0, 3'b000};
         last_r = 32'h0;
      end else if (en) begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = in_valid ? ref_mul(a, b) : '{1'b0, 32'h0, 3'b000};
         if (pipe[2].v) last_r = pipe[2].r;
      end
      #1;
      chk("out_valid", {31'h0, out_valid}, {31'h0, pipe[2].v});
      chk("result", result, last_r);
      chk("flags", {29'h0, ovf, unf, inv}, (FLAGS && pipe[2].v) ? {29'h0, pipe[2].f} : 32'h0);
   end
   task automatic drive(input logic e, input logic v, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      en = e;
      in_valid = v;
      a = x;
      b = y;
   endtask
   task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r, input logic [2:0] f);
      drive(1'b1, 1'b1, x, y);
      drive(1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("dir_valid", {31'h0, out_valid}, 32'h1);
      chk("dir_result", result, r);
      chk("dir_flags", {29'h0, ovf, unf, inv}, FLAGS ? {29'h0, f} : 32'h0);
   endtask
   logic [31:0] da [12] = '{32'h41B26666, 32'h40CCCCCC, 32'h40000000, 32'h7F800000, 32'h00000000, 32'hFF800000,
                            32'h7FC00001, 32'h3F800001, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h00400000};
   logic [31:0] db [12] = '{32'hBF000000, 32'hBF000000, 32'h40400000, 32'h404CCCCC, 32'h404CCCCC, 32'h00000000,
                            32'h3F800000, 32'h3F800001, 32'h3FC00000, 32'h40000000, 32'h3F000000, 32'h3F800000};
   logic [31:0] dr [12] = '{32'hC1326666, 32'hC04CCCCC, 32'h40C00000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                            32'h7FC00000, 32'h3F800002, 32'h3FC00002, 32'h7F800000, 32'h00000000, 32'h00000000};
   logic [2:0]  df [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001,
                            3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b000};
   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      #2;
      chk("reset_valid", {31'h0, out_valid}, 32'h0);
      chk("reset_result", result, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) run_one(da[i], db[i], dr[i], df[i]);
      // six ops, two-cycle stall after op 3, bubble after op 5
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, rand_fp(), rand_fp());
      repeat (2) drive(1'b0, 1'b1, rand_fp(), rand_fp());
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, rand_fp(), rand_fp());
      drive(1'b1, 1'b0, rand_fp(), rand_fp());
      drive(1'b1, 1'b1, rand_fp(), rand_fp());
      repeat (4) drive(1'b1, 1'b0, 32'h0, 32'h0);
      // reset with two ops still in flight
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 32'h40000000, 32'h40400000);
      @(negedge clk);
      chk("pre_reset_valid", {31'h0, out_valid}, 32'h1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", {31'h0, out_valid}, 32'h0);
      chk("async_reset_result", result, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) drive(1'b1, 1'b0, 32'h0, 32'h0);
      repeat (600) drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, rand_fp(), rand_fp());
      repeat (5) drive(1'b1, 1'b0, 32'h0, 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
